// File: rtl/attn_ctrl_pkg.sv
// Shared types, defaults and helpers for the attention pipeline flow controller.
package attn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam int DEF_PIPE_LAT   = 3;
    localparam int DEF_OBUF_DEPTH = 4;
    localparam int DEF_ID_WIDTH   = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/attn_tag_fifo.sv
// Tag store for results parked in the external result buffer: tag memory,
// read/write pointers and occupancy. Pointers double as the buffer addresses.
module attn_tag_fifo
    import attn_ctrl_pkg::*;
#(
    parameter int OBUF_DEPTH = DEF_OBUF_DEPTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clr,
    input  logic                         i_wr_en,
    input  logic [ID_WIDTH-1:0]          i_wr_id,
    input  logic                         i_pop,
    output logic [clog2(OBUF_DEPTH)-1:0] o_wr_addr,
    output logic [clog2(OBUF_DEPTH)-1:0] o_rd_addr,
    output logic [ID_WIDTH-1:0]          o_rd_id,
    output logic                         o_not_empty
);
    localparam int            AW      = clog2(OBUF_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(OBUF_DEPTH);

    logic [OBUF_DEPTH-1:0][ID_WIDTH-1:0] r_tag_mem;
    logic [AW-1:0]                       r_wr_ptr;
    logic [AW-1:0]                       r_rd_ptr;
    logic [AW:0]                         r_buf_cnt;

    assign o_wr_addr   = r_wr_ptr;
    assign o_rd_addr   = r_rd_ptr;
    assign o_rd_id     = r_tag_mem[r_rd_ptr];
    assign o_not_empty = (r_buf_cnt != '0);

    // Tag memory is cleared only by reset so out_id reads zero afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_mem <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_buf_cnt <= '0;
        end else if (i_clr) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_buf_cnt <= '0;
        end else begin
            if (i_wr_en) begin
                r_tag_mem[r_wr_ptr] <= i_wr_id;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_wr_en, i_pop})
                2'b10:   r_buf_cnt <= r_buf_cnt + 1'b1;
                2'b01:   r_buf_cnt <= r_buf_cnt - 1'b1;
                default: r_buf_cnt <= r_buf_cnt;
            endcase
        end
    end

    // Credits guarantee a free slot for every write leaving the pipeline.
    always_ff @(posedge clk) begin
        if (rst_n && !i_clr && i_wr_en) assert (r_buf_cnt < DEPTH_C);
    end

endmodule

// File: rtl/attn_pipe_ctrl.sv
// Flow controller for the fixed-latency QK -> softmax -> SV pipeline: launch
// pulses, valid/ID tracking, result buffer addressing and credits.
// Optional ATTN_CTRL_PERF_EN adds saturating launch/backpressure/stall counters.
module attn_pipe_ctrl
    import attn_ctrl_pkg::*;
#(
    parameter int PIPE_LAT   = DEF_PIPE_LAT,
    parameter int OBUF_DEPTH = DEF_OBUF_DEPTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ID_WIDTH-1:0]          in_id,
    output logic                         launch,
    input  logic                         flush,
    output logic                         obuf_wr_en,
    output logic [clog2(OBUF_DEPTH)-1:0] obuf_wr_addr,
    output logic [clog2(OBUF_DEPTH)-1:0] obuf_rd_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ID_WIDTH-1:0]          out_id,
    output logic                         busy,
    output logic [clog2(OBUF_DEPTH):0]   occ_cnt
`ifdef ATTN_CTRL_PERF_EN
    ,
    output logic [31:0]                  perf_launch_cnt,
    output logic [31:0]                  perf_bp_cnt,
    output logic [31:0]                  perf_stall_cnt
`endif
);
    localparam int          AW      = clog2(OBUF_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(OBUF_DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    state_t                            r_state;
    state_t                            w_state;
    state_t                            w_state_nxt;
    logic [PIPE_LAT-1:0]               r_vld_pipe;
    logic [PIPE_LAT-1:0][ID_WIDTH-1:0] r_id_pipe;
    logic [AW:0]                       r_occ_cnt;
    logic                              w_pop;

    assign in_ready   = (r_occ_cnt < DEPTH_C) & ~flush;
    assign launch     = in_valid & in_ready;
    assign obuf_wr_en = r_vld_pipe[PIPE_LAT-1] & ~flush;
    assign w_pop      = out_valid & out_ready & ~flush;
    assign occ_cnt    = r_occ_cnt;
    assign busy       = (w_state != IDLE);

    // Pipeline never stalls: the tracker shifts every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_vld_pipe <= '0;
            r_id_pipe  <= '0;
        end else begin
            r_vld_pipe[0] <= launch;
            r_id_pipe[0]  <= in_id;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_id_pipe[i]  <= r_id_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_occ_cnt <= '0;
        end else begin
            case ({launch, w_pop})
                2'b10:   r_occ_cnt <= r_occ_cnt + ONE_C;
                2'b01:   r_occ_cnt <= r_occ_cnt - ONE_C;
                default: r_occ_cnt <= r_occ_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // FLUSH is the state seen during the flush cycle itself; it always exits to IDLE.
    always_comb begin
        w_state     = flush ? FLUSH : r_state;
        w_state_nxt = w_state;
        case (w_state)
            IDLE:    if (launch) w_state_nxt = ACTIVE;
            ACTIVE:  if ((r_occ_cnt == '0) || ((r_occ_cnt == ONE_C) && w_pop && !launch))
                         w_state_nxt = IDLE;
            FLUSH:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    attn_tag_fifo #(
        .OBUF_DEPTH (OBUF_DEPTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (flush),
        .i_wr_en     (obuf_wr_en),
        .i_wr_id     (r_id_pipe[PIPE_LAT-1]),
        .i_pop       (w_pop),
        .o_wr_addr   (obuf_wr_addr),
        .o_rd_addr   (obuf_rd_addr),
        .o_rd_id     (out_id),
        .o_not_empty (out_valid)
    );

`ifdef ATTN_CTRL_PERF_EN
    logic [31:0] r_perf_launch;
    logic [31:0] r_perf_bp;
    logic [31:0] r_perf_stall;

    assign perf_launch_cnt = r_perf_launch;
    assign perf_bp_cnt     = r_perf_bp;
    assign perf_stall_cnt  = r_perf_stall;

    // Counters survive flush; only reset clears them. They stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_launch <= '0;
            r_perf_bp     <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (launch && (r_perf_launch != '1))
                r_perf_launch <= r_perf_launch + 32'd1;
            if (in_valid && !in_ready && (r_perf_bp != '1))
                r_perf_bp <= r_perf_bp + 32'd1;
            if (out_valid && !out_ready && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_attn_pipe_ctrl.sv
// Self-checking bench for attn_pipe_ctrl: directed vector table, hand sequences
// and a randomized run against a queue-based reference model.
module tb_attn_pipe_ctrl;
    localparam int LAT = 3;
    localparam int D   = 4;
    localparam int IDW = 4;

    logic           clk = 1'b0;
    logic           rst_n, in_valid, in_ready, launch, flush, obuf_wr_en;
    logic           out_valid, out_ready, busy;
    logic [IDW-1:0] in_id, out_id;
    logic [1:0]     obuf_wr_addr, obuf_rd_addr;
    logic [2:0]     occ_cnt;
`ifdef ATTN_CTRL_PERF_EN
    logic [31:0]    perf_launch_cnt, perf_bp_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    attn_pipe_ctrl #(.PIPE_LAT(LAT), .OBUF_DEPTH(D), .ID_WIDTH(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_id(in_id), .launch(launch), .flush(flush), .obuf_wr_en(obuf_wr_en),
        .obuf_wr_addr(obuf_wr_addr), .obuf_rd_addr(obuf_rd_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .busy(busy), .occ_cnt(occ_cnt)
`ifdef ATTN_CTRL_PERF_EN
        , .perf_launch_cnt(perf_launch_cnt), .perf_bp_cnt(perf_bp_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Reference model: requests in flight carry their launch cycle; a result
    // lands in the buffer exactly LAT cycles after its launch.
    typedef struct {int id; int t;} flight_t;
    flight_t q_fly[$];
    int      q_buf[$];
    int      wr_cnt = 0, rd_cnt = 0;
    int      m_launch = 0, m_bp = 0, m_stall = 0;

    logic s_ir, s_launch, s_wr, s_ov, s_pop, s_busy;
    int   s_wa, s_ra, s_oid, s_occ;

    task automatic step(input logic iv, input int id, input logic ordy, input logic fl, input logic rs);
        int      occ;
        logic    e_ir, e_launch, e_wr, e_ov, e_pop;
        flight_t f;
        in_valid = iv; in_id = IDW'(id); out_ready = ordy; flush = fl; rst_n = rs;
        @(negedge clk);
        occ      = q_fly.size() + q_buf.size();
        e_ir     = (occ < D) && !fl;
        e_launch = iv && e_ir;
        e_wr     = (q_fly.size() != 0) && (q_fly[0].t + LAT == cyc_n) && !fl;
        e_ov     = (q_buf.size() != 0);
        e_pop    = e_ov && ordy && !fl;
        s_ir = in_ready; s_launch = launch; s_wr = obuf_wr_en; s_ov = out_valid;
        s_pop = out_valid & out_ready & ~flush; s_busy = busy;
        s_wa = int'(obuf_wr_addr); s_ra = int'(obuf_rd_addr); s_oid = int'(out_id); s_occ = int'(occ_cnt);
        if (rs) begin
            chk("m_in_ready", in_ready, e_ir);
            chk("m_launch", launch, e_launch);
            chk("m_wr_en", obuf_wr_en, e_wr);
            chk("m_wr_addr", obuf_wr_addr, wr_cnt % D);
            chk("m_out_valid", out_valid, e_ov);
            if (e_ov) chk("m_out_id", out_id, q_buf[0]);
            chk("m_rd_addr", obuf_rd_addr, rd_cnt % D);
            chk("m_busy", busy, fl || (occ != 0));
            chk("m_occ", occ_cnt, occ);
`ifdef ATTN_CTRL_PERF_EN
            chk("m_perf_launch", perf_launch_cnt, m_launch);
            chk("m_perf_bp", perf_bp_cnt, m_bp);
            chk("m_perf_stall", perf_stall_cnt, m_stall);
`endif
        end
        @(posedge clk); #1;
        if (!rs) begin
            q_fly.delete(); q_buf.delete(); wr_cnt = 0; rd_cnt = 0;
            m_launch = 0; m_bp = 0; m_stall = 0;
        end else begin
            m_launch += int'(e_launch);
            m_bp     += int'(iv && !e_ir);
            m_stall  += int'(e_ov && !ordy);
            if (fl) begin
                q_fly.delete(); q_buf.delete(); wr_cnt = 0; rd_cnt = 0;
            end else begin
                if (e_pop) begin void'(q_buf.pop_front()); rd_cnt++; end
                if (e_wr) begin f = q_fly.pop_front(); q_buf.push_back(f.id); wr_cnt++; end
                if (e_launch) begin f.id = id % 16; f.t = cyc_n; q_fly.push_back(f); end
            end
        end
        cyc_n++;
    endtask

    typedef struct {
        logic iv; int id; logic ordy; logic fl;
        logic ir; logic wr; int wa; logic ov; int oid; int ra; logic bsy; int occ;
    } vec_t;
    vec_t tbl[13];

    int nl, nid;
    int waq[$], popq[$], lq[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time %0t, limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          iv id ordy fl | ir wr wa ov oid ra busy occ
        tbl[0]  = '{1, 5, 1, 0,    1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0,    1, 0, 0, 0, 0, 0, 1, 1};
        tbl[2]  = '{0, 0, 1, 0,    1, 0, 0, 0, 0, 0, 1, 1};
        tbl[3]  = '{0, 0, 1, 0,    1, 1, 0, 0, 0, 0, 1, 1};
        tbl[4]  = '{0, 0, 1, 0,    1, 0, 1, 1, 5, 0, 1, 1};
        tbl[5]  = '{0, 0, 1, 0,    1, 0, 1, 0, 0, 1, 0, 0};
        tbl[6]  = '{1, 7, 0, 0,    1, 0, 1, 0, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0,    1, 0, 1, 0, 0, 1, 1, 1};
        tbl[8]  = '{1, 8, 0, 0,    1, 0, 1, 0, 0, 1, 1, 1};
        tbl[9]  = '{1, 9, 0, 0,    1, 1, 1, 0, 0, 1, 1, 2};
        tbl[10] = '{1, 10, 0, 1,   0, 0, 2, 1, 7, 1, 1, 3};
        tbl[11] = '{0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0};

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst_n = 1'b1; in_valid = 1'b0; #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wr_en", obuf_wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_occ", occ_cnt, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_wr_addr", obuf_wr_addr, 0);
        chk("rst_rd_addr", obuf_rd_addr, 0);
`ifdef ATTN_CTRL_PERF_EN
        chk("rst_perf", perf_launch_cnt | perf_bp_cnt | perf_stall_cnt, 0);
`endif

        // Single request, then flush with two in flight and one buffered.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl, 1);
            chk($sformatf("tbl%0d_in_ready", i), s_ir, tbl[i].ir);
            chk($sformatf("tbl%0d_launch", i), s_launch, tbl[i].iv & tbl[i].ir);
            chk($sformatf("tbl%0d_wr_en", i), s_wr, tbl[i].wr);
            chk($sformatf("tbl%0d_wr_addr", i), s_wa, tbl[i].wa);
            chk($sformatf("tbl%0d_out_valid", i), s_ov, tbl[i].ov);
            if (tbl[i].ov) chk($sformatf("tbl%0d_out_id", i), s_oid, tbl[i].oid);
            chk($sformatf("tbl%0d_rd_addr", i), s_ra, tbl[i].ra);
            chk($sformatf("tbl%0d_busy", i), s_busy, tbl[i].bsy);
            chk($sformatf("tbl%0d_occ", i), s_occ, tbl[i].occ);
        end

        // Saturation: out_ready low for 10 cycles, IDs 0..5 offered back to back.
        step(0, 0, 0, 0, 0);
        nl = 0; nid = 0; waq.delete(); popq.delete();
        for (int c = 0; c < 20; c++) begin
            step(nid <= 5, nid, c >= 10, 0, 1);
            if (s_launch) begin
                nid++;
                if (c < 10) nl++;
            end
            if (s_wr) waq.push_back(s_wa);
            if (s_pop) popq.push_back(s_oid);
            if (c == 9)  chk("sat_in_ready_blocked", s_ir, 0);
            if (c == 11) chk("sat_in_ready_reassert", s_ir, 1);
        end
        chk("sat_launches", nl, 4);
        chk("sat_writes", waq.size(), 6);
        for (int k = 0; k < waq.size() && k < 4; k++) chk("sat_wr_addr", waq[k], k);
        chk("sat_pops", popq.size(), 6);
        for (int k = 0; k < popq.size(); k++) chk("sat_order", popq[k], k);
`ifdef ATTN_CTRL_PERF_EN
        chk("sat_perf_launch", perf_launch_cnt, 6);
        chk("sat_perf_bp", perf_bp_cnt, 7);
        chk("sat_perf_stall", perf_stall_cnt, 6);
`endif

        // Streaming with out_ready high until 20 launches; pointers wrap.
        nl = 0; lq.delete(); popq.delete();
        for (int c = 0; c < 60 && nl < 20; c++) begin
            step(1, (nl + 3) % 16, 1, 0, 1);
            if (s_launch) begin lq.push_back((nl + 3) % 16); nl++; end
            if (s_pop) popq.push_back(s_oid);
        end
        for (int c = 0; c < 8; c++) begin
            step(0, 0, 1, 0, 1);
            if (s_pop) popq.push_back(s_oid);
        end
        chk("stream_launches", nl, 20);
        chk("stream_pops", popq.size(), 20);
        for (int k = 0; k < popq.size() && k < lq.size(); k++) chk("stream_order", popq[k], lq[k]);

        // Launch and pop in the same cycle with two entries buffered.
        step(1, 11, 0, 0, 1);
        step(1, 12, 0, 0, 1);
        for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 1);
        step(1, 13, 1, 0, 1);
        chk("lp_occ_before", s_occ, 2);
        chk("lp_pop", s_pop, 1);
        chk("lp_launch", s_launch, 1);
        step(0, 0, 0, 0, 1);
        chk("lp_occ_after", s_occ, 2);
        chk("lp_out_id", s_oid, 12);
        for (int c = 0; c < 8; c++) step(0, 0, 1, 0, 1);

        // Reset mid-stream while a result is presented.
        step(1, 1, 0, 0, 1);
        step(1, 2, 0, 0, 1);
        step(1, 3, 0, 0, 1);
        step(1, 4, 0, 0, 1);
        step(1, 5, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("mrst_occ", s_occ, 0);
        chk("mrst_out_valid", s_ov, 0);
        chk("mrst_busy", s_busy, 0);
        chk("mrst_wr_en", s_wr, 0);
        chk("mrst_out_id", s_oid, 0);
        chk("mrst_addrs", s_wa + s_ra, 0);
        chk("mrst_in_ready", s_ir, 1);
`ifdef ATTN_CTRL_PERF_EN
        chk("mrst_perf", perf_launch_cnt | perf_bp_cnt | perf_stall_cnt, 0);
`endif

        // Randomized traffic including occasional flush and reset.
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
                 $urandom_range(0, 80) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
